fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 10, program address width.
REQ-002 Parameter INSTR_W, default 18, instruction width.
REQ-003 Parameter RESET_PC, default 10'h000, first fetch address after reset.
REQ-004 Parameter INTR_VEC, default 10'h3FF, interrupt vector address.
REQ-005 CLK  in  1  sole clock, all state on rising edge.
REQ-006 RST  in  1  asynchronous, active-high reset.
REQ-007 STALL  in  1  downstream cannot accept the presented instruction.
REQ-008 BR_EN  in  1  load PC from BR_ADDR (jump/branch/call).
REQ-009 BR_ADDR  in  ADDR_W  branch target.
REQ-010 RET_EN  in  1  load PC from RET_ADDR (RET/RETIE).
REQ-011 RET_ADDR  in  ADDR_W  return address from stack.
REQ-012 INTR  in  1  level interrupt request, held until INTR_ACK.
REQ-013 ROM_ADDR  out  ADDR_W  address to program ROM (synchronous read, 1-cycle latency).
REQ-014 ROM_IR  in  INSTR_W  data from program ROM.
REQ-015 IR  out  INSTR_W  instruction presented downstream.
REQ-016 IR_VALID  out  1  IR is a live instruction.
REQ-017 IR_PC  out  ADDR_W  address of IR.
REQ-018 LINK_PC  out  ADDR_W  IR_PC+1 modulo 2^ADDR_W, for CALL/interrupt push.
REQ-019 INTR_ACK  out  1  one-cycle pulse, interrupt taken.

Function
REQ-020 ROM_ADDR SHALL be driven combinationally from fetch register pc_q.
REQ-021 FSM states SHALL be FILL, RUN, HOLD.
REQ-022 FILL: IR_VALID=0; next edge pc_q<=pc_q+1, inflight_pc<=pc_q, ->RUN.
REQ-023 RUN: IR=ROM_IR, IR_PC=inflight_pc, IR_VALID=1.
REQ-024 Instruction consumed on any edge with IR_VALID=1 and STALL=0.
REQ-025 RUN, STALL=1: hold_ir<=ROM_IR, hold_pc<=inflight_pc, pc_q unchanged, ->HOLD.
REQ-026 HOLD: IR=hold_ir, IR_PC=hold_pc, IR_VALID=1; STALL=1 stays; STALL=0 consumes, pc_q<=pc_q+1, inflight_pc<=pc_q, ->RUN.
REQ-027 RUN, STALL=0, no redirect: pc_q<=pc_q+1, inflight_pc<=pc_q, stay RUN.
REQ-028 Redirect SHALL occur only on a consuming edge; redirect inputs ignored while STALL=1 or IR_VALID=0.
REQ-029 Redirect priority INTR > RET_EN > BR_EN; target INTR_VEC / RET_ADDR / BR_ADDR.
REQ-030 On redirect: pc_q<=target, ->FILL; in-flight ROM word squashed (never valid).
REQ-031 Redirect-to-valid latency: IR_VALID=1 with IR_PC=target exactly 2 cycles after the redirect edge.
REQ-032 INTR_ACK SHALL be 1 in the cycle the interrupt is taken (same cycle as consuming edge); INTR during FILL deferred.
REQ-033 PC increment SHALL wrap 0x3FF->0x000 silently; LINK_PC wraps likewise.
REQ-034 HOLD with redirect pending: redirect applied on the edge STALL drops.

Reset
REQ-035 RST=1 SHALL immediately force pc_q=RESET_PC, state=FILL, IR_VALID=0, INTR_ACK=0, IR=0, IR_PC=0, hold_ir=0, hold_pc=0.
REQ-036 Reset mid-HOLD or mid-FILL SHALL discard held/in-flight instruction; first valid after release is rom[RESET_PC] at 2nd edge.

Structure
REQ-037 Package rat_fetch_pkg SHALL hold ADDR_W/INSTR_W defaults, INTR_VEC, fetch-state enum, redirect-select enum.
REQ-038 Sub-module prog_counter (pc_q register, increment, target mux) SHALL be instantiated; FSM and hold buffer in fetch_unit.

Verification (ROM model: synchronous, rom[a]={8'h00,a})
REQ-039 Reset release, no stall -> IR_VALID rises 2nd edge, IR=0x00000, then 0x00001, 0x00002 each cycle.
REQ-040 STALL high 3 cycles while IR_PC=0x005 -> IR stays 0x00005 all 3 cycles, next cycle 0x00006, no skip/duplicate.
REQ-041 BR_EN with BR_ADDR=0x120 on consuming edge at IR_PC=0x010 -> one IR_VALID=0 cycle, then IR_PC=0x120, 0x121.
REQ-042 INTR and RET_EN (RET_ADDR=0x050) same edge at IR_PC=0x030 -> INTR_ACK=1, LINK_PC=0x031, next valid IR_PC=0x3FF then 0x000.
REQ-043 INTR asserted during FILL -> INTR_ACK only on first consuming edge, not earlier.
REQ-044 RST pulse during HOLD -> IR_VALID=0 immediately; restart sequence from 0x000 as REQ-039.

Source files
------------

// File: rtl/rat_fetch_pkg.sv
// Shared definitions for the instruction fetch front end: default widths,
// interrupt vector, fetch-state and redirect-select encodings.
package rat_fetch_pkg;

    localparam int         ADDR_W_DEF   = 10;
    localparam int         INSTR_W_DEF  = 18;
    localparam logic [9:0] INTR_VEC_DEF = 10'h3FF;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        SEL_SEQ  = 2'd0,
        SEL_INTR = 2'd1,
        SEL_RET  = 2'd2,
        SEL_BR   = 2'd3
    } redir_sel_t;

    // Interrupt beats return, return beats branch.
    function automatic redir_sel_t redir_pick(input logic intr, input logic ret, input logic br);
        if (intr)
            return SEL_INTR;
        else if (ret)
            return SEL_RET;
        else if (br)
            return SEL_BR;
        else
            return SEL_SEQ;
    endfunction

endpackage

// File: rtl/prog_counter.sv
// Fetch address register: sequential increment or load of a redirect target.
import rat_fetch_pkg::*;

module prog_counter #(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] INTR_VEC = ADDR_W'(INTR_VEC_DEF)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              advance,
    input  logic [1:0]        sel,
    input  logic [ADDR_W-1:0] ret_addr,
    input  logic [ADDR_W-1:0] br_addr,
    output logic [ADDR_W-1:0] pc_q
);

    logic [ADDR_W-1:0] target;
    logic              load;

    assign load = advance || (sel != SEL_SEQ);

    // Sequential increment wraps naturally at the top of the address space.
    always_comb begin
        target = pc_q + ADDR_W'(1);
        case (sel)
            SEL_INTR: target = INTR_VEC;
            SEL_RET:  target = ret_addr;
            SEL_BR:   target = br_addr;
            default:  target = pc_q + ADDR_W'(1);
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            pc_q <= RESET_PC;
        else if (load)
            pc_q <= target;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: drives a synchronous program ROM, presents one
// instruction per cycle, buffers it under stall and handles redirects.
import rat_fetch_pkg::*;

module fetch_unit #(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter logic [ADDR_W-1:0] INTR_VEC = ADDR_W'(INTR_VEC_DEF)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               STALL,
    input  logic               BR_EN,
    input  logic [ADDR_W-1:0]  BR_ADDR,
    input  logic               RET_EN,
    input  logic [ADDR_W-1:0]  RET_ADDR,
    input  logic               INTR,
    output logic [ADDR_W-1:0]  ROM_ADDR,
    input  logic [INSTR_W-1:0] ROM_IR,
    output logic [INSTR_W-1:0] IR,
    output logic               IR_VALID,
    output logic [ADDR_W-1:0]  IR_PC,
    output logic [ADDR_W-1:0]  LINK_PC,
    output logic               INTR_ACK
);

    localparam logic [1:0] FILL = ST_FILL;
    localparam logic [1:0] RUN  = ST_RUN;
    localparam logic [1:0] HOLD = ST_HOLD;

    logic [1:0]         state;
    logic [1:0]         state_next;
    logic [ADDR_W-1:0]  pc_q;
    logic [ADDR_W-1:0]  inflight_pc;
    logic [INSTR_W-1:0] hold_ir;
    logic [ADDR_W-1:0]  hold_pc;
    logic               consume;
    logic               redirect;
    logic               advance;
    logic [1:0]         sel;

    assign IR_VALID = (state == RUN) || (state == HOLD);
    assign consume  = IR_VALID && !STALL;
    // Redirect inputs only matter on an edge that actually takes an instruction.
    assign sel      = consume ? redir_pick(INTR, RET_EN, BR_EN) : SEL_SEQ;
    assign redirect = (sel != SEL_SEQ);
    assign advance  = (state == FILL) || consume;
    assign INTR_ACK = consume && INTR;
    assign ROM_ADDR = pc_q;

    prog_counter #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC),
        .INTR_VEC (INTR_VEC)
    ) u_pc (
        .CLK      (CLK),
        .RST      (RST),
        .advance  (advance),
        .sel      (sel),
        .ret_addr (RET_ADDR),
        .br_addr  (BR_ADDR),
        .pc_q     (pc_q)
    );

    always_comb begin
        state_next = state;
        case (state)
            FILL:      state_next = RUN;
            RUN, HOLD: begin
                if (consume)
                    state_next = redirect ? FILL : RUN;
                else
                    state_next = HOLD;
            end
            default:   state_next = FILL;
        endcase
    end

    // inflight_pc names the word the ROM returns next cycle; after a redirect
    // it holds a squashed address that FILL never presents.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= FILL;
            inflight_pc <= '0;
            hold_ir     <= '0;
            hold_pc     <= '0;
        end else begin
            state <= state_next;
            if (advance)
                inflight_pc <= pc_q;
            if ((state == RUN) && STALL) begin
                hold_ir <= ROM_IR;
                hold_pc <= inflight_pc;
            end
        end
    end

    always_comb begin
        IR    = '0;
        IR_PC = '0;
        case (state)
            RUN: begin
                IR    = ROM_IR;
                IR_PC = inflight_pc;
            end
            HOLD: begin
                IR    = hold_ir;
                IR_PC = hold_pc;
            end
            default: begin
                IR    = '0;
                IR_PC = '0;
            end
        endcase
    end

    assign LINK_PC = IR_PC + ADDR_W'(1);

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized and directed bench for fetch_unit with a synchronous ROM model
// and a scoreboard of expected instruction addresses.
module tb_fetch_unit;

    localparam int         AW       = 10;
    localparam int         IW       = 18;
    localparam logic [9:0] RST_PC   = 10'h000;
    localparam logic [9:0] VEC      = 10'h3FF;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          STALL = 1'b0;
    logic          BR_EN = 1'b0;
    logic [AW-1:0] BR_ADDR = '0;
    logic          RET_EN = 1'b0;
    logic [AW-1:0] RET_ADDR = '0;
    logic          INTR = 1'b0;
    logic [AW-1:0] ROM_ADDR;
    logic [IW-1:0] ROM_IR;
    logic [IW-1:0] IR;
    logic          IR_VALID;
    logic [AW-1:0] IR_PC;
    logic [AW-1:0] LINK_PC;
    logic          INTR_ACK;

    int vectors = 0;
    int miscompares = 0;
    int bubble = 1;
    logic [AW-1:0] exp_q[$];
    logic [AW-1:0] p;
    logic [AW-1:0] pn;

    always #5 CLK = ~CLK;

    fetch_unit dut (
        .CLK      (CLK),
        .RST      (RST),
        .STALL    (STALL),
        .BR_EN    (BR_EN),
        .BR_ADDR  (BR_ADDR),
        .RET_EN   (RET_EN),
        .RET_ADDR (RET_ADDR),
        .INTR     (INTR),
        .ROM_ADDR (ROM_ADDR),
        .ROM_IR   (ROM_IR),
        .IR       (IR),
        .IR_VALID (IR_VALID),
        .IR_PC    (IR_PC),
        .LINK_PC  (LINK_PC),
        .INTR_ACK (INTR_ACK)
    );

    // Program ROM: registered read, each word encodes its own address.
    always @(posedge CLK) ROM_IR <= {8'h00, ROM_ADDR};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, req, $time);
        end
    endtask

    // Model: an instruction stream that restarts at RESET_PC after reset,
    // inserts one empty cycle after reset or any taken redirect, repeats the
    // current instruction while stalled, and otherwise advances by one.
    always @(negedge CLK) begin
        if (RST) begin
            chk("rst_valid", IR_VALID, 0);
            chk("rst_ir", IR, 0);
            chk("rst_ir_pc", IR_PC, 0);
            chk("rst_ack", INTR_ACK, 0);
            exp_q.delete();
            exp_q.push_back(RST_PC);
            bubble = 1;
        end else if (bubble > 0) begin
            chk("bubble_valid", IR_VALID, 0);
            chk("bubble_ack", INTR_ACK, 0);
            bubble--;
        end else begin
            chk("sb_depth", exp_q.size(), 1);
            if (exp_q.size() > 0) begin
                p  = exp_q[0];
                pn = p + 10'd1;
                chk("valid", IR_VALID, 1);
                chk("ir_pc", IR_PC, p);
                chk("ir", IR, {8'h00, p});
                chk("link_pc", LINK_PC, pn);
                chk("intr_ack", INTR_ACK, INTR && !STALL);
                if (!STALL) begin
                    void'(exp_q.pop_front());
                    if (INTR) begin
                        exp_q.push_back(VEC);
                        bubble = 1;
                    end else if (RET_EN) begin
                        exp_q.push_back(RET_ADDR);
                        bubble = 1;
                    end else if (BR_EN) begin
                        exp_q.push_back(BR_ADDR);
                        bubble = 1;
                    end else begin
                        exp_q.push_back(pn);
                    end
                    $display("t=%0t consume pc=%03h ir=%05h link=%03h ack=%0b next=%03h",
                             $time, IR_PC, IR, LINK_PC, INTR_ACK, exp_q[0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_pc(input logic [AW-1:0] t);
        bit found = 0;
        for (int i = 0; i < 300; i++) begin
            if (IR_VALID && IR_PC == t) begin
                found = 1;
                break;
            end
            step();
        end
        if (!found) chk("wait_pc", IR_PC, t);
    endtask

    initial begin
        repeat (3) step();
        RST = 1'b0;

        // Sequential fetch from reset, then a 3-cycle stall at 0x005.
        wait_pc(10'h005);
        STALL = 1'b1;
        repeat (3) step();
        STALL = 1'b0;

        // Branch at 0x010 to 0x120.
        wait_pc(10'h010);
        BR_EN = 1'b1; BR_ADDR = 10'h120;
        step();
        BR_EN = 1'b0;
        wait_pc(10'h121);
        BR_EN = 1'b1; BR_ADDR = 10'h02C;
        step();
        BR_EN = 1'b0;

        // Interrupt and return together at 0x030: interrupt wins, then wrap.
        wait_pc(10'h030);
        INTR = 1'b1; RET_EN = 1'b1; RET_ADDR = 10'h050;
        step();
        INTR = 1'b0; RET_EN = 1'b0;
        wait_pc(10'h000);
        wait_pc(10'h002);

        // Interrupt raised during FILL is only taken on the first consuming edge.
        BR_EN = 1'b1; BR_ADDR = 10'h200;
        step();
        BR_EN = 1'b0;
        INTR = 1'b1;
        step();
        step();
        INTR = 1'b0;
        wait_pc(10'h3FF);

        // Reset pulse while holding a stalled instruction.
        wait_pc(10'h001);
        STALL = 1'b1;
        step();
        step();
        #2 RST = 1'b1;
        #1 chk("rst_async_valid", IR_VALID, 0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        STALL = 1'b0;
        wait_pc(10'h003);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 1500; i++) begin
            STALL    = ($urandom % 4) == 0;
            BR_EN    = ($urandom % 8) == 0;
            BR_ADDR  = 10'($urandom);
            RET_EN   = ($urandom % 10) == 0;
            RET_ADDR = 10'($urandom);
            INTR     = ($urandom % 12) == 0;
            RST      = ($urandom % 400) == 0;
            step();
        end
        RST = 1'b0; STALL = 1'b0; BR_EN = 1'b0; RET_EN = 1'b0; INTR = 1'b0;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
